nx_fifo_wr_arb: RTL and testbench

NX_FIFO_WR_ARB -- requirements
Module: nx_fifo_wr_arb

---
 rtl/nx_fifo_wr_arb.sv | 120 ++++++++++++
 tb/tb_nx_fifo_wr_arb.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_wr_arb.sv
// nx_fifo_wr_arb: round-robin arbiter merging 4 requesters onto one FIFO write port.
// Define NX_FIFO_ARB_LOCK_EN to hold the grant on one requester until its eop beat.
module nx_fifo_wr_arb #(
  parameter int NREQ = 4,
  parameter int DW   = 68,
  parameter int FSW  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]   req_eop,
  output logic [NREQ-1:0]   gnt,
  output logic              fifo_wen,
  output logic [DW+2:0]     fifo_wdata,
  input  logic [FSW-1:0]    fifo_free_slots,
  input  logic              fifo_overflow,
  output logic              arb_busy,
  output logic              arb_err
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] win;
  logic       pend_q, pend_d;
  logic       err_d;
  logic       can_wr;
  logic       xfer;
  logic       win_eop;
  logic [7:0] req2;
  logic [3:0] rot;

  // One registered write may still be in flight toward the FIFO.
  assign can_wr  = fifo_free_slots > FSW'(fifo_wen);
  assign req2    = {req, req};
  assign rot     = req2[ptr_q +: 4];
  assign xfer    = |gnt;
  assign win_eop = req_eop[win];

  always_comb begin
    win = ptr_q;
    gnt = '0;
    if (state_q == LOCKED) begin
      win = owner_q;
    end else begin
      priority case (1'b1)
        rot[0]:  win = ptr_q;
        rot[1]:  win = ptr_q + 2'd1;
        rot[2]:  win = ptr_q + 2'd2;
        rot[3]:  win = ptr_q + 2'd3;
        default: win = ptr_q;
      endcase
    end
    if (rst_n && !clear && can_wr && req[win])
      gnt[win] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    err_d   = arb_err | fifo_overflow;
    // Owner was waiting on a stall last cycle; dropping req now is illegal.
    pend_d  = (state_q == LOCKED) && req[owner_q]
              && !gnt[owner_q];
    if (state_q == LOCKED && pend_q && !req[owner_q])
      err_d = 1'b1;
    if (xfer) begin
      ptr_d = win + 2'd1;
`ifdef NX_FIFO_ARB_LOCK_EN
      if (state_q == IDLE && !win_eop) begin
        state_d = LOCKED;
        owner_d = win;
      end else if (state_q == LOCKED && win_eop) begin
        state_d = IDLE;
      end
`endif
    end
    if (clear) begin
      state_d = IDLE;
      ptr_d   = '0;
      owner_d = '0;
      pend_d  = 1'b0;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      pend_q     <= 1'b0;
      arb_err    <= 1'b0;
      fifo_wen   <= 1'b0;
      fifo_wdata <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      pend_q   <= pend_d;
      arb_err  <= err_d;
      fifo_wen <= xfer;
      if (xfer)
        fifo_wdata <= {win, win_eop,
                       req_data[32'(win)*DW +: DW]};
    end
  end

`ifdef NX_FIFO_ARB_LOCK_EN
  assign arb_busy = (state_q == LOCKED);
`else
  assign arb_busy = 1'b0;
`endif

endmodule

// File: tb/tb_nx_fifo_wr_arb.sv
// tb_nx_fifo_wr_arb: directed bench for nx_fifo_wr_arb.
// Lock scenarios run when NX_FIFO_ARB_LOCK_EN is defined.
module tb_nx_fifo_wr_arb;

  localparam int DW  = 68;
  localparam int FSW = 12;

  typedef logic [127:0] w_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic [3:0]      req;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_eop;
  logic [3:0]      gnt;
  logic            fifo_wen;
  logic [DW+2:0]   fifo_wdata;
  logic [FSW-1:0]  free;
  logic            ovf;
  logic            arb_busy;
  logic            arb_err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nx_fifo_wr_arb #(.NREQ(4), .DW(DW), .FSW(FSW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .clear           (clear),
    .req             (req),
    .req_data        (req_data),
    .req_eop         (req_eop),
    .gnt             (gnt),
    .fifo_wen        (fifo_wen),
    .fifo_wdata      (fifo_wdata),
    .fifo_free_slots (free),
    .fifo_overflow   (ovf),
    .arb_busy        (arb_busy),
    .arb_err         (arb_err)
  );

  function automatic logic [DW-1:0] dat(input int i, input int k);
    return {4'(i + 1), 32'(k), 32'h5A5A_0000 + 32'(i)};
  endfunction

  function automatic logic [DW+2:0] wexp(input int i, input logic e,
                                         input int k);
    return {2'(i), e, dat(i, k)};
  endfunction

  task automatic chk(input string tag, input w_t obs, input w_t exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_dat(input int i, input int k);
    req_data[i*DW +: DW] = dat(i, k);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; ovf = 1'b0; free = 12'd100;
    req = 4'b1111; req_eop = 4'b1111;
    for (int i = 0; i < 4; i++) set_dat(i, 0);
    #2;
    chk("rst_wen",   w_t'(fifo_wen),   w_t'(1'b0));
    chk("rst_wdata", w_t'(fifo_wdata), w_t'(0));
    chk("rst_gnt",   w_t'(gnt),        w_t'(4'b0000));
    chk("rst_busy",  w_t'(arb_busy),   w_t'(1'b0));
    chk("rst_err",   w_t'(arb_err),    w_t'(1'b0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // all requesting, all eop: plain rotation
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_gnt", w_t'(gnt), w_t'(4'b0001 << (k % 4)));
      chk("rr_wen", w_t'(fifo_wen), w_t'(k > 0));
      if (k > 0)
        chk("rr_wdata", w_t'(fifo_wdata),
            w_t'(wexp((k - 1) % 4, 1'b1, 0)));
      @(negedge clk);
    end
    req = 4'b0000;
    #1 chk("last_wdata", w_t'(fifo_wdata), w_t'(wexp(0, 1'b1, 0)));
    @(negedge clk);
    #1;
    chk("idle_wen",  w_t'(fifo_wen),   w_t'(1'b0));
    chk("hold_data", w_t'(fifo_wdata), w_t'(wexp(0, 1'b1, 0)));

    // one free slot
    free = 12'd1; req = 4'b0100;
    #1 chk("full_gnt0", w_t'(gnt), w_t'(4'b0100));
    @(negedge clk);
    #1;
    chk("full_block", w_t'(gnt),        w_t'(4'b0000));
    chk("full_wen",   w_t'(fifo_wen),   w_t'(1'b1));
    chk("full_wdata", w_t'(fifo_wdata), w_t'(wexp(2, 1'b1, 0)));
    @(negedge clk);
    #1 chk("full_resume", w_t'(gnt), w_t'(4'b0100));
    free = 12'd0;
    #1 chk("zero_slots", w_t'(gnt), w_t'(4'b0000));
    req = 4'b0000; free = 12'd100;

    // ptr=3: wraps to requester 0, then 1
    req = 4'b0011;
    #1 chk("wrap_gnt", w_t'(gnt), w_t'(4'b0001));
    @(negedge clk);
    #1 chk("wrap_next", w_t'(gnt), w_t'(4'b0010));
    req = 4'b0000;

    // overflow is sticky until clear
    @(negedge clk); ovf = 1'b1;
    @(negedge clk); ovf = 1'b0;
    #1 chk("ovf_err", w_t'(arb_err), w_t'(1'b1));
    @(negedge clk);
    #1 chk("ovf_hold", w_t'(arb_err), w_t'(1'b1));
    req = 4'b1001; clear = 1'b1;
    #1 chk("clr_gnt", w_t'(gnt), w_t'(4'b0000));
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr_err",  w_t'(arb_err),  w_t'(1'b0));
    chk("clr_wen",  w_t'(fifo_wen), w_t'(1'b0));
    chk("clr_ptr",  w_t'(gnt),      w_t'(4'b0001));
    req = 4'b0000;

`ifdef NX_FIFO_ARB_LOCK_EN
    @(negedge clk);
    req = 4'b0011; req_eop = 4'b1110; set_dat(0, 1);
    #1;
    chk("lk_gnt1",  w_t'(gnt),      w_t'(4'b0001));
    chk("lk_busy1", w_t'(arb_busy), w_t'(1'b0));
    @(negedge clk);
    set_dat(0, 2);
    #1;
    chk("lk_gnt2",  w_t'(gnt),        w_t'(4'b0001));
    chk("lk_busy2", w_t'(arb_busy),   w_t'(1'b1));
    chk("lk_dat1",  w_t'(fifo_wdata), w_t'(wexp(0, 1'b0, 1)));
    @(negedge clk);
    req_eop = 4'b1111; set_dat(0, 3);
    #1;
    chk("lk_gnt3",  w_t'(gnt),        w_t'(4'b0001));
    chk("lk_busy3", w_t'(arb_busy),   w_t'(1'b1));
    chk("lk_dat2",  w_t'(fifo_wdata), w_t'(wexp(0, 1'b0, 2)));
    @(negedge clk);
    req = 4'b0010;
    #1;
    chk("lk_rel_busy", w_t'(arb_busy),   w_t'(1'b0));
    chk("lk_rel_gnt",  w_t'(gnt),        w_t'(4'b0010));
    chk("lk_dat3",     w_t'(fifo_wdata), w_t'(wexp(0, 1'b1, 3)));
    @(negedge clk);
    req = 4'b0000;
    #1 chk("lk_next", w_t'(fifo_wdata), w_t'(wexp(1, 1'b1, 0)));

    // owner drops req while stalled
    @(negedge clk);
    req = 4'b0001; req_eop = 4'b1110;
    @(negedge clk); free = 12'd0;
    @(negedge clk); req = 4'b0000; free = 12'd100;
    @(negedge clk);
    #1 chk("proto_err", w_t'(arb_err), w_t'(1'b1));
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("proto_clr",  w_t'(arb_err),  w_t'(1'b0));
    chk("proto_busy", w_t'(arb_busy), w_t'(1'b0));
`else
    @(negedge clk);
    req = 4'b0011; req_eop = 4'b1110;
    #1 chk("nl_gnt1", w_t'(gnt), w_t'(4'b0001));
    @(negedge clk);
    #1;
    chk("nl_gnt2",  w_t'(gnt),        w_t'(4'b0010));
    chk("nl_busy",  w_t'(arb_busy),   w_t'(1'b0));
    chk("nl_wdata", w_t'(fifo_wdata), w_t'(wexp(0, 1'b0, 0)));
    req = 4'b0000;
`endif

    // reset in the middle of a packet
    @(negedge clk);
    req = 4'b0001; req_eop = 4'b1110;
    @(negedge clk);
    #1 chk("mid_wen", w_t'(fifo_wen), w_t'(1'b1));
`ifdef NX_FIFO_ARB_LOCK_EN
    chk("mid_busy", w_t'(arb_busy), w_t'(1'b1));
`endif
    #1 rst_n = 1'b0;
    #1;
    chk("ar_wen",   w_t'(fifo_wen),   w_t'(1'b0));
    chk("ar_busy",  w_t'(arb_busy),   w_t'(1'b0));
    chk("ar_wdata", w_t'(fifo_wdata), w_t'(0));
    chk("ar_gnt",   w_t'(gnt),        w_t'(4'b0000));
    @(negedge clk);
    rst_n = 1'b1; req = 4'b0100;
    #1 chk("post_gnt", w_t'(gnt), w_t'(4'b0100));
    @(negedge clk);
    req = 4'b0000;
    #1;
    chk("post_wen",   w_t'(fifo_wen),   w_t'(1'b1));
    chk("post_wdata", w_t'(fifo_wdata), w_t'(wexp(2, 1'b1, 0)));
    @(negedge clk);
    #1 chk("post_idle", w_t'(fifo_wen), w_t'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
